// File: rtl/fpmul_round_pack_pkg.sv
// Shared types and constants for the FP back ends: EXE bus bundle, rounding modes, fflags layout.
package riscv_types;

  localparam int unsigned XADDR_W = 5;

  typedef struct packed {
    logic [XADDR_W-1:0] rd;
    logic               reg_write;
    logic               FP_reg_write;
    logic [3:0]         op_tag;
  } exe_p_mux_bus_type;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;

  typedef enum int unsigned {
    FF_NX = 0,
    FF_UF = 1,
    FF_OF = 2,
    FF_DZ = 3,
    FF_NV = 4
  } fflag_idx_e;

  typedef struct packed {
    logic [23:0]       sum;
    logic [7:0]        exp;
    logic              sign;
    logic              inexact;
    logic              is_nan;
    logic              nv;
    logic              is_inf;
    logic              is_zero;
    logic [2:0]        rm;
    logic              p;
    exe_p_mux_bus_type bus;
  } rp_stage1_t;

endpackage

// File: rtl/fpmul_round_pack_if.sv
// Unrounded operand bundle handed from the fpmul front end to the round/pack back end.
interface fpmul_round_pack_if;
  logic        sign_i;
  logic [7:0]  exp_i;
  logic [46:0] mant_i;
  logic        is_NaN_i;
  logic        nv_i;
  logic        is_inf_i;
  logic        is_zero_i;

  modport master (output sign_i, exp_i, mant_i, is_NaN_i, nv_i, is_inf_i, is_zero_i);
  modport slave  (input  sign_i, exp_i, mant_i, is_NaN_i, nv_i, is_inf_i, is_zero_i);
endinterface

// File: rtl/fp_round_decide.sv
// Round-increment decision shared by the FP back ends; reserved modes fall back to RNE.
module fp_round_decide
  import riscv_types::*;
(
  input  logic [2:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       s,
  output logic       up
);

  always_comb begin
    up = 1'b0;
    case (rm)
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = (g | s) & sign;
      RM_RUP:  up = (g | s) & ~sign;
      RM_RMM:  up = g;
      default: up = g & (s | lsb);
    endcase
  end

endmodule

// File: rtl/fpmul_round_pack.sv
// FP multiply back end: stage 1 decides rounding, stage 2 packs binary32 and fflags.
module fpmul_round_pack
  import riscv_types::*;
#(
  parameter int unsigned addr_width = 5,
  parameter int unsigned num_rds    = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 en,
  input  logic [num_rds-1:0]                   clear,
  fpmul_round_pack_if.slave                    fe,
  input  logic [2:0]                           rm,
  input  logic                                 P_signal,
  input  exe_p_mux_bus_type                    pipeline_signals_i,
  output logic [31:0]                          result_o,
  output logic [4:0]                           fflags_o,
  output logic                                 P_O_signal,
  output exe_p_mux_bus_type                    pipeline_signals_o,
  output logic [num_rds-1:0][addr_width-1:0]   uu_rd,
  output logic [num_rds-1:0]                   uu_reg_write,
  output logic [num_rds-1:0]                   uu_FP_reg_write
);

  logic              w_up;
  rp_stage1_t        w_s1;
  rp_stage1_t        r_s1;

  logic              w_carry;
  logic [8:0]        w_exp9;
  logic [22:0]       w_frac;
  logic              w_ovf;
  logic              w_to_inf;
  logic [31:0]       w_result;
  logic [4:0]        w_fflags;

  logic [31:0]       r_result;
  logic [4:0]        r_fflags;
  logic              r_p;
  exe_p_mux_bus_type r_bus;

  fp_round_decide u_round (
    .rm   (rm),
    .sign (fe.sign_i),
    .lsb  (fe.mant_i[24]),
    .g    (fe.mant_i[23]),
    .s    (|fe.mant_i[22:0]),
    .up   (w_up)
  );

  always_comb begin
    w_s1         = '0;
    w_s1.sum     = {1'b0, fe.mant_i[46:24]} + {23'b0, w_up};
    w_s1.exp     = fe.exp_i;
    w_s1.sign    = fe.sign_i;
    w_s1.inexact = fe.mant_i[23] | (|fe.mant_i[22:0]);
    w_s1.is_nan  = fe.is_NaN_i;
    w_s1.nv      = fe.nv_i;
    w_s1.is_inf  = fe.is_inf_i;
    w_s1.is_zero = fe.is_zero_i;
    w_s1.rm      = rm;
    w_s1.p       = P_signal;
    w_s1.bus     = pipeline_signals_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_s1 <= '0;
    else if (clear[1]) r_s1 <= '0;
    else if (en)       r_s1 <= w_s1;
  end

  // Mantissa carry-out bumps the exponent; this also lifts exp=0 to the smallest normal.
  assign w_carry = r_s1.sum[23];
  assign w_exp9  = {1'b0, r_s1.exp} + {8'b0, w_carry};
  assign w_frac  = w_carry ? '0 : r_s1.sum[22:0];
  assign w_ovf   = (w_exp9 >= 9'h0FF);

  always_comb begin
    w_to_inf = 1'b1;
    case (r_s1.rm)
      RM_RTZ:  w_to_inf = 1'b0;
      RM_RDN:  w_to_inf = r_s1.sign;
      RM_RUP:  w_to_inf = ~r_s1.sign;
      default: w_to_inf = 1'b1;
    endcase
  end

  always_comb begin
    w_result = '0;
    w_fflags = '0;
    if (r_s1.is_nan) begin
      w_result        = FP_CANON_NAN;
      w_fflags[FF_NV] = r_s1.nv;
    end else if (r_s1.is_inf) begin
      w_result = {r_s1.sign, 8'hFF, 23'h0};
    end else if (r_s1.is_zero) begin
      w_result = {r_s1.sign, 31'h0};
    end else if (w_ovf) begin
      w_result        = w_to_inf ? {r_s1.sign, 8'hFF, 23'h0} : {r_s1.sign, 8'hFE, 23'h7FFFFF};
      w_fflags[FF_OF] = 1'b1;
      w_fflags[FF_NX] = 1'b1;
    end else begin
      w_result        = {r_s1.sign, w_exp9[7:0], w_frac};
      w_fflags[FF_UF] = (w_exp9[7:0] == 8'h00) & r_s1.inexact;
      w_fflags[FF_NX] = r_s1.inexact;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_fflags <= '0;
      r_p      <= 1'b0;
      r_bus    <= '0;
    end else if (clear[0]) begin
      r_result <= '0;
      r_fflags <= '0;
      r_p      <= 1'b0;
      r_bus    <= '0;
    end else if (en) begin
      r_result <= w_result;
      r_fflags <= w_fflags;
      r_p      <= r_s1.p;
      r_bus    <= r_s1.bus;
    end
  end

  assign result_o           = r_result;
  assign fflags_o           = r_fflags;
  assign P_O_signal         = r_p;
  assign pipeline_signals_o = r_bus;

  assign uu_rd[1]           = addr_width'(r_s1.bus.rd);
  assign uu_rd[0]           = addr_width'(r_bus.rd);
  assign uu_reg_write[1]    = r_s1.bus.reg_write;
  assign uu_reg_write[0]    = r_bus.reg_write;
  assign uu_FP_reg_write[1] = r_s1.bus.FP_reg_write;
  assign uu_FP_reg_write[0] = r_bus.FP_reg_write;

endmodule

// File: tb/tb_fpmul_round_pack.sv
// Directed-vector bench for fpmul_round_pack: rounding, packing, specials and pipeline control.
module tb_fpmul_round_pack;
  import riscv_types::*;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [1:0]        clear;
  logic [2:0]        rm;
  logic              P_signal;
  exe_p_mux_bus_type pipeline_signals_i;
  logic [31:0]       result_o;
  logic [4:0]        fflags_o;
  logic              P_O_signal;
  exe_p_mux_bus_type pipeline_signals_o;
  logic [1:0][4:0]   uu_rd;
  logic [1:0]        uu_reg_write;
  logic [1:0]        uu_FP_reg_write;

  int vectors;
  int miscompares;

  fpmul_round_pack_if fe ();

  fpmul_round_pack #(.addr_width(5), .num_rds(2)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .en                 (en),
    .clear              (clear),
    .fe                 (fe),
    .rm                 (rm),
    .P_signal           (P_signal),
    .pipeline_signals_i (pipeline_signals_i),
    .result_o           (result_o),
    .fflags_o           (fflags_o),
    .P_O_signal         (P_O_signal),
    .pipeline_signals_o (pipeline_signals_o),
    .uu_rd              (uu_rd),
    .uu_reg_write       (uu_reg_write),
    .uu_FP_reg_write    (uu_FP_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flg = {nan, nv, inf, zero}
  task automatic drive(input logic s, input logic [7:0] e, input logic [22:0] f, input logic g,
                       input logic [22:0] st, input logic [2:0] m, input logic [3:0] flg,
                       input logic [4:0] rd, input logic rw, input logic fprw, input logic [3:0] tag,
                       input logic p);
    fe.sign_i    = s;
    fe.exp_i     = e;
    fe.mant_i    = {f, g, st};
    fe.is_NaN_i  = flg[3];
    fe.nv_i      = flg[2];
    fe.is_inf_i  = flg[1];
    fe.is_zero_i = flg[0];
    rm           = m;
    pipeline_signals_i.rd           = rd;
    pipeline_signals_i.reg_write    = rw;
    pipeline_signals_i.FP_reg_write = fprw;
    pipeline_signals_i.op_tag       = tag;
    P_signal     = p;
  endtask

  task automatic run_op(input logic s, input logic [7:0] e, input logic [22:0] f, input logic g,
                        input logic [22:0] st, input logic [2:0] m, input logic [3:0] flg);
    drive(s, e, f, g, st, m, flg, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    if (result_o !== 32'h0) begin $display("FAIL reset_result got %h want %h", result_o, 32'h0); miscompares++; end vectors++;
    if (fflags_o !== 5'h0) begin $display("FAIL reset_fflags got %b want %b", fflags_o, 5'h0); miscompares++; end vectors++;
    if ({P_O_signal, pipeline_signals_o, uu_reg_write, uu_FP_reg_write} !== '0) begin
      $display("FAIL reset_ctrl got %b_%h_%b_%b want all zero", P_O_signal, pipeline_signals_o, uu_reg_write, uu_FP_reg_write); miscompares++; end vectors++;
  endtask

  task automatic test_basic();
    drive(1'b0, 8'h80, 23'h100000, 1'b0, 23'h0, RM_RNE, 4'b0000, 5'd9, 1'b1, 1'b1, 4'd5, 1'b1);
    tick();
    tick();
    if (result_o !== 32'h40100000) begin $display("FAIL basic_result got %h want %h", result_o, 32'h40100000); miscompares++; end vectors++;
    if (fflags_o !== 5'b00000) begin $display("FAIL basic_fflags got %b want %b", fflags_o, 5'b00000); miscompares++; end vectors++;
    if (P_O_signal !== 1'b1 || pipeline_signals_o.rd !== 5'd9 || pipeline_signals_o.op_tag !== 4'd5) begin
      $display("FAIL basic_sideband got p=%b rd=%0d tag=%0d want p=1 rd=9 tag=5", P_O_signal, pipeline_signals_o.rd, pipeline_signals_o.op_tag); miscompares++; end vectors++;
  endtask

  task automatic test_tie_even();
    run_op(1'b0, 8'h7F, 23'h000001, 1'b1, 23'h0, RM_RNE, 4'b0000);
    if (result_o !== 32'h3F800002) begin $display("FAIL tie_rne_result got %h want %h", result_o, 32'h3F800002); miscompares++; end vectors++;
    if (fflags_o !== 5'b00001) begin $display("FAIL tie_rne_fflags got %b want %b", fflags_o, 5'b00001); miscompares++; end vectors++;
    run_op(1'b0, 8'h7F, 23'h000001, 1'b1, 23'h0, RM_RTZ, 4'b0000);
    if (result_o !== 32'h3F800001) begin $display("FAIL tie_rtz_result got %h want %h", result_o, 32'h3F800001); miscompares++; end vectors++;
    run_op(1'b0, 8'h7F, 23'h000002, 1'b1, 23'h0, 3'b110, 4'b0000);
    if (result_o !== 32'h3F800002) begin $display("FAIL tie_reserved_result got %h want %h", result_o, 32'h3F800002); miscompares++; end vectors++;
    run_op(1'b1, 8'h7F, 23'h000002, 1'b1, 23'h0, RM_RMM, 4'b0000);
    if (result_o !== 32'hBF800003) begin $display("FAIL tie_rmm_result got %h want %h", result_o, 32'hBF800003); miscompares++; end vectors++;
    run_op(1'b1, 8'h7F, 23'h000002, 1'b0, 23'h1, RM_RUP, 4'b0000);
    if (result_o !== 32'hBF800002) begin $display("FAIL rup_neg_result got %h want %h", result_o, 32'hBF800002); miscompares++; end vectors++;
  endtask

  task automatic test_overflow();
    run_op(1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 23'h0, RM_RNE, 4'b0000);
    if (result_o !== 32'h7F800000) begin $display("FAIL ovf_rne_result got %h want %h", result_o, 32'h7F800000); miscompares++; end vectors++;
    if (fflags_o !== 5'b00101) begin $display("FAIL ovf_rne_fflags got %b want %b", fflags_o, 5'b00101); miscompares++; end vectors++;
    run_op(1'b0, 8'hFE, 23'h7FFFFF, 1'b1, 23'h0, RM_RTZ, 4'b0000);
    if (result_o !== 32'h7F7FFFFF) begin $display("FAIL ovf_rtz_result got %h want %h", result_o, 32'h7F7FFFFF); miscompares++; end vectors++;
    run_op(1'b0, 8'hFF, 23'h0, 1'b0, 23'h0, RM_RTZ, 4'b0000);
    if (result_o !== 32'h7F7FFFFF) begin $display("FAIL ovf_expff_rtz_result got %h want %h", result_o, 32'h7F7FFFFF); miscompares++; end vectors++;
    if (fflags_o !== 5'b00101) begin $display("FAIL ovf_expff_rtz_fflags got %b want %b", fflags_o, 5'b00101); miscompares++; end vectors++;
    run_op(1'b1, 8'hFE, 23'h7FFFFF, 1'b1, 23'h0, RM_RDN, 4'b0000);
    if (result_o !== 32'hFF800000) begin $display("FAIL ovf_rdn_neg_result got %h want %h", result_o, 32'hFF800000); miscompares++; end vectors++;
    run_op(1'b1, 8'hFF, 23'h0, 1'b0, 23'h0, RM_RUP, 4'b0000);
    if (result_o !== 32'hFF7FFFFF) begin $display("FAIL ovf_rup_neg_result got %h want %h", result_o, 32'hFF7FFFFF); miscompares++; end vectors++;
  endtask

  task automatic test_specials();
    run_op(1'b1, 8'h12, 23'h1234, 1'b1, 23'h0, RM_RNE, 4'b1100);
    if (result_o !== 32'h7FC00000) begin $display("FAIL nan_result got %h want %h", result_o, 32'h7FC00000); miscompares++; end vectors++;
    if (fflags_o !== 5'b10000) begin $display("FAIL nan_fflags got %b want %b", fflags_o, 5'b10000); miscompares++; end vectors++;
    run_op(1'b1, 8'h00, 23'h0, 1'b1, 23'h5, RM_RNE, 4'b0010);
    if (result_o !== 32'hFF800000) begin $display("FAIL inf_result got %h want %h", result_o, 32'hFF800000); miscompares++; end vectors++;
    if (fflags_o !== 5'b00000) begin $display("FAIL inf_fflags got %b want %b", fflags_o, 5'b00000); miscompares++; end vectors++;
    run_op(1'b1, 8'h00, 23'h0, 1'b0, 23'h0, RM_RNE, 4'b0001);
    if (result_o !== 32'h80000000) begin $display("FAIL zero_result got %h want %h", result_o, 32'h80000000); miscompares++; end vectors++;
  endtask

  task automatic test_subnormal();
    run_op(1'b0, 8'h00, 23'h7FFFFF, 1'b1, 23'h0, RM_RNE, 4'b0000);
    if (result_o !== 32'h00800000) begin $display("FAIL subn_carry_result got %h want %h", result_o, 32'h00800000); miscompares++; end vectors++;
    if (fflags_o !== 5'b00001) begin $display("FAIL subn_carry_fflags got %b want %b", fflags_o, 5'b00001); miscompares++; end vectors++;
    run_op(1'b0, 8'h00, 23'h000001, 1'b1, 23'h0, RM_RTZ, 4'b0000);
    if (result_o !== 32'h00000001) begin $display("FAIL subn_uf_result got %h want %h", result_o, 32'h00000001); miscompares++; end vectors++;
    if (fflags_o !== 5'b00011) begin $display("FAIL subn_uf_fflags got %b want %b", fflags_o, 5'b00011); miscompares++; end vectors++;
  endtask

  task automatic test_back_to_back();
    en = 1'b1;
    drive(1'b0, 8'h80, 23'h100000, 1'b0, 23'h0, RM_RNE, 4'b0000, 5'd1, 1'b1, 1'b0, 4'd1, 1'b1);
    tick();
    drive(1'b0, 8'h7F, 23'h000001, 1'b1, 23'h0, RM_RNE, 4'b0000, 5'd2, 1'b1, 1'b0, 4'd2, 1'b0);
    tick();
    if (result_o !== 32'h40100000 || pipeline_signals_o.op_tag !== 4'd1 || P_O_signal !== 1'b1) begin
      $display("FAIL b2b_first got %h tag=%0d p=%b want 40100000 tag=1 p=1", result_o, pipeline_signals_o.op_tag, P_O_signal); miscompares++; end vectors++;
    drive(1'b0, 8'h00, 23'h0, 1'b0, 23'h0, RM_RNE, 4'b1100, 5'd3, 1'b1, 1'b0, 4'd3, 1'b0);
    en = 1'b0;
    tick();
    if (result_o !== 32'h40100000 || pipeline_signals_o.op_tag !== 4'd1) begin
      $display("FAIL b2b_hold got %h tag=%0d want 40100000 tag=1", result_o, pipeline_signals_o.op_tag); miscompares++; end vectors++;
    en = 1'b1;
    tick();
    if (result_o !== 32'h3F800002 || pipeline_signals_o.op_tag !== 4'd2 || fflags_o !== 5'b00001) begin
      $display("FAIL b2b_second got %h tag=%0d ff=%b want 3f800002 tag=2 ff=00001", result_o, pipeline_signals_o.op_tag, fflags_o); miscompares++; end vectors++;
    tick();
    if (result_o !== 32'h7FC00000 || pipeline_signals_o.op_tag !== 4'd3 || fflags_o !== 5'b10000) begin
      $display("FAIL b2b_third got %h tag=%0d ff=%b want 7fc00000 tag=3 ff=10000", result_o, pipeline_signals_o.op_tag, fflags_o); miscompares++; end vectors++;
  endtask

  task automatic test_clear();
    en = 1'b1;
    clear = 2'b00;
    drive(1'b0, 8'h80, 23'h100000, 1'b0, 23'h0, RM_RNE, 4'b0000, 5'd3, 1'b1, 1'b0, 4'd1, 1'b0);
    tick();
    drive(1'b0, 8'h7F, 23'h000001, 1'b1, 23'h0, RM_RNE, 4'b0000, 5'd7, 1'b1, 1'b1, 4'd2, 1'b0);
    tick();
    if (uu_reg_write !== 2'b11 || uu_FP_reg_write !== 2'b10 || uu_rd[1] !== 5'd7 || uu_rd[0] !== 5'd3) begin
      $display("FAIL uu_full got rw=%b fprw=%b rd1=%0d rd0=%0d want rw=11 fprw=10 rd1=7 rd0=3", uu_reg_write, uu_FP_reg_write, uu_rd[1], uu_rd[0]); miscompares++; end vectors++;
    drive(1'b0, 8'h80, 23'h0, 1'b0, 23'h0, RM_RNE, 4'b0000, 5'd9, 1'b1, 1'b1, 4'd3, 1'b1);
    clear = 2'b10;
    tick();
    if (uu_reg_write !== 2'b01 || uu_rd[0] !== 5'd7 || result_o !== 32'h3F800002) begin
      $display("FAIL clear1_flush got rw=%b rd0=%0d res=%h want rw=01 rd0=7 res=3f800002", uu_reg_write, uu_rd[0], result_o); miscompares++; end vectors++;
    clear = 2'b00;
    drive(1'b0, 8'h00, 23'h0, 1'b0, 23'h0, RM_RNE, 4'b0001, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    if (result_o !== 32'h0 || pipeline_signals_o !== '0 || P_O_signal !== 1'b0) begin
      $display("FAIL clear1_bubble got res=%h bus=%h p=%b want all zero", result_o, pipeline_signals_o, P_O_signal); miscompares++; end vectors++;
    drive(1'b0, 8'h80, 23'h100000, 1'b0, 23'h0, RM_RNE, 4'b0000, 5'd4, 1'b1, 1'b0, 4'd4, 1'b1);
    tick();
    tick();
    en = 1'b0;
    clear = 2'b11;
    tick();
    if (uu_reg_write !== 2'b00 || result_o !== 32'h0 || P_O_signal !== 1'b0) begin
      $display("FAIL clear_both_en0 got rw=%b res=%h p=%b want rw=00 res=0 p=0", uu_reg_write, result_o, P_O_signal); miscompares++; end vectors++;
    clear = 2'b00;
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    drive(1'b0, 8'h80, 23'h100000, 1'b0, 23'h1, RM_RNE, 4'b0000, 5'd6, 1'b1, 1'b1, 4'd6, 1'b1);
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    if (result_o !== 32'h0 || fflags_o !== 5'h0 || P_O_signal !== 1'b0 || pipeline_signals_o !== '0 || uu_reg_write !== 2'b00) begin
      $display("FAIL async_reset got res=%h ff=%b p=%b bus=%h rw=%b want all zero", result_o, fflags_o, P_O_signal, pipeline_signals_o, uu_reg_write); miscompares++; end vectors++;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    en = 1'b1;
    clear = 2'b00;
    drive(1'b0, 8'h00, 23'h0, 1'b0, 23'h0, RM_RNE, 4'b0000, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic();
    test_tie_even();
    test_overflow();
    test_specials();
    test_subnormal();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
